// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent two-phase timers with per-channel prescaler,
// one-shot mode and an end-of-cycle done pulse.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   cfg_we/ch/addr  config write: addr 0=period_a 1=period_b 2=divisor 3=mode
//   cfg_wdata       config data, truncated to the field width
//   set, reset      per-channel start/stop requests, rising-edge detected
//   enabled         channel running
//   out             channel waveform (high in phase A)
//   done            one-cycle pulse at the end of each phase B
//   gate            per-channel count enable (only with TIMER_BANK_GATE_EN)
//
// Optional feature: define TIMER_BANK_GATE_EN to add the gate input.
module timer_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic [NUM_CH-1:0] set,
    input  logic [NUM_CH-1:0] reset,
    output logic [NUM_CH-1:0] enabled,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] done
`ifdef TIMER_BANK_GATE_EN
    ,
    input  logic [NUM_CH-1:0] gate
`endif
);

    localparam int PW = 2 ** DIV_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_A = 2'd1,
        PHASE_B = 2'd2
    } state_t;

    logic [NUM_CH-1:0] set_prev;
    logic [NUM_CH-1:0] reset_prev;
    logic [NUM_CH-1:0] set_edge;
    logic [NUM_CH-1:0] reset_edge;

    assign set_edge   = set & ~set_prev;
    assign reset_edge = reset & ~reset_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_prev   <= '0;
            reset_prev <= '0;
        end else begin
            set_prev   <= set;
            reset_prev <= reset;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] period_a;
        logic [CNT_W-1:0] period_b;
        logic [DIV_W-1:0] divisor;
        logic             oneshot;
        logic             cfg_hit;
        logic             run;
        logic             tick;
        logic [PW-1:0]    pre_max;
        state_t           st_q;
        state_t           st_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [PW-1:0]    pre_q;
        logic [PW-1:0]    pre_d;
        logic             done_q;
        logic             done_d;

        // cfg_ch values at or above NUM_CH never match any channel
        assign cfg_hit = cfg_we && (cfg_ch == 3'(i));

`ifdef TIMER_BANK_GATE_EN
        assign run = gate[i];
`else
        assign run = 1'b1;
`endif

        assign pre_max = (PW'(1) << divisor) - PW'(1);
        assign tick    = run && (pre_q == pre_max);

        always_ff @(posedge clk) begin
            if (rst) begin
                period_a <= CNT_W'(2);
                period_b <= CNT_W'(3);
                divisor  <= '0;
                oneshot  <= 1'b0;
            end else if (cfg_hit) begin
                case (cfg_addr)
                    2'd0:    period_a <= cfg_wdata;
                    2'd1:    period_b <= cfg_wdata;
                    2'd2:    divisor  <= cfg_wdata[DIV_W-1:0];
                    default: oneshot  <= cfg_wdata[0];
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pre_q  <= '0;
                done_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pre_q  <= pre_d;
                done_q <= done_d;
            end
        end

        // Compares use the live period registers; a smaller new period than
        // the running count lets the counter wrap before it matches.
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            pre_d  = pre_q;
            done_d = 1'b0;
            if (reset_edge[i]) begin
                st_d  = IDLE;
                cnt_d = '0;
                pre_d = '0;
            end else if (set_edge[i]) begin
                st_d  = PHASE_A;
                cnt_d = '0;
                pre_d = '0;
            end else begin
                unique case (st_q)
                    IDLE: begin
                        cnt_d = '0;
                        pre_d = '0;
                    end
                    PHASE_A: begin
                        if (run) begin
                            pre_d = tick ? '0 : pre_q + PW'(1);
                        end
                        if (tick) begin
                            if (cnt_q == period_a) begin
                                st_d  = PHASE_B;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    PHASE_B: begin
                        if (run) begin
                            pre_d = tick ? '0 : pre_q + PW'(1);
                        end
                        if (tick) begin
                            if (cnt_q == period_b) begin
                                done_d = 1'b1;
                                cnt_d  = '0;
                                st_d   = oneshot ? IDLE : PHASE_A;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        cnt_d = '0;
                        pre_d = '0;
                    end
                endcase
            end
        end

        assign enabled[i] = (st_q != IDLE);
        assign out[i]     = (st_q == PHASE_A);
        assign done[i]    = done_q;
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank waveforms, one-shot, stop
// priority, live period rewrite with wrap, ignored writes and mid-run reset.
module tb_timer_bank;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [2:0]   cfg_ch;
    logic [1:0]   cfg_addr;
    logic [9:0]   cfg_wdata;
    logic [N-1:0] set;
    logic [N-1:0] reset;
    logic [N-1:0] enabled;
    logic [N-1:0] out;
    logic [N-1:0] done;
    logic [N-1:0] gate;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_bank #(.NUM_CH(N), .CNT_W(10), .DIV_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .set      (set),
        .reset    (reset),
        .enabled  (enabled),
        .out      (out),
        .done     (done)
`ifdef TIMER_BANK_GATE_EN
        ,
        .gate     (gate)
`endif
    );

    typedef struct {
        logic [N-1:0] set;
        logic [N-1:0] rs;
        logic [N-1:0] en;
        logic [N-1:0] out;
        logic [N-1:0] done;
    } vec_t;

    vec_t tab [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] a,
                             input logic [9:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int k;
        logic [3:0] hi;

        // ch0 with reset defaults: 3 high, 4 low, done on re-entry to A
        for (int r = 0; r < 15; r++) begin
            hi = 4'b0111 | 4'b1000;
            k  = r % 7;
            tab[r].set  = 4'b0001;
            tab[r].rs   = 4'b0000;
            tab[r].en   = 4'b0001;
            tab[r].out  = (k < 3) ? 4'b0001 : 4'b0000;
            tab[r].done = (r == 7 || r == 14) ? 4'b0001 : 4'b0000;
        end
        tab[15].set  = 4'b0001;
        tab[15].rs   = 4'b0001;
        tab[15].en   = 4'b0000;
        tab[15].out  = 4'b0000;
        tab[15].done = 4'b0000;

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0;
        cfg_wdata = '0; set = '0; reset = '0; gate = '1;
        step();
        step();
        rst = 1'b0;
        chk("reset_en", int'(enabled), 0);
        chk("reset_out", int'(out), 0);
        chk("reset_done", int'(done), 0);

        for (int r = 0; r < 16; r++) begin
            set   = tab[r].set;
            reset = tab[r].rs;
            step();
            chk($sformatf("tab%0d_en", r), int'(enabled), int'(tab[r].en));
            chk($sformatf("tab%0d_out", r), int'(out), int'(tab[r].out));
            chk($sformatf("tab%0d_done", r), int'(done), int'(tab[r].done));
        end

        // ch1 one-shot, divisor 2: 4 high, 8 low, one done
        cfg_write(3'd1, 2'd0, 10'd0);
        cfg_write(3'd1, 2'd1, 10'd1);
        cfg_write(3'd1, 2'd2, 10'd2);
        cfg_write(3'd1, 2'd3, 10'd1);
        set[1] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            chk($sformatf("os%0d_out", j), int'(out[1]), int'(j < 4));
            chk($sformatf("os%0d_en", j), int'(enabled[1]), int'(j < 12));
            chk($sformatf("os%0d_done", j), int'(done[1]), int'(j == 12));
        end

        // ch2: set and reset rising together, reset wins
        set[2] = 1'b1;
        step();
        chk("ch2_start", int'(out[2]), 1);
        step();
        step();
        set[2] = 1'b0;
        step();
        set[2]   = 1'b1;
        reset[2] = 1'b1;
        step();
        chk("ch2_stop", int'({enabled[2], out[2], done[2]}), 0);
        for (int j = 0; j < 10; j++) begin
            step();
            chk($sformatf("ch2_quiet%0d", j),
                int'({enabled[2], out[2], done[2]}), 0);
        end

        // ch0: shrink period_a below the running count, counter wraps
        cfg_write(3'd0, 2'd0, 10'd5);
        set[0]   = 1'b0;
        reset[0] = 1'b0;
        step();
        set[0] = 1'b1;
        step();
        chk("wrap_start", int'(out[0]), 1);
        step();
        step();
        cfg_write(3'd0, 2'd0, 10'd1);
        chk("wrap_after_wr", int'(out[0]), 1);
        cnt = 0;
        while (out[0] == 1'b1 && cnt < 2000) begin
            step();
            cnt++;
        end
        chk("wrap_len", cnt, 1023);

        // rst mid phase B, then writes to absent channels are ignored
        rst = 1'b1; set = '0; reset = '0; cfg_we = 1'b0;
        step();
        rst = 1'b0;
        chk("rst2_en", int'(enabled), 0);
        chk("rst2_out", int'(out), 0);
        chk("rst2_done", int'(done), 0);
        cfg_write(3'd5, 2'd0, 10'd7);
        cfg_write(3'd4, 2'd1, 10'd9);
        cfg_write(3'd5, 2'd2, 10'd3);
        cfg_write(3'd5, 2'd3, 10'd1);
        set = 4'b0011;
        for (int j = 0; j < 9; j++) begin
            step();
            chk($sformatf("def%0d_out", j), int'(out[1:0]),
                (j < 3 || j >= 7) ? 3 : 0);
            chk($sformatf("def%0d_done", j), int'(done[1:0]),
                (j == 7) ? 3 : 0);
            chk($sformatf("def%0d_en", j), int'(enabled[1:0]), 3);
        end

`ifdef TIMER_BANK_GATE_EN
        // ch3: gating mid phase A stretches it by exactly the gated cycles
        set[3] = 1'b1;
        step();
        step();
        gate[3] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            chk($sformatf("gate%0d_out", j), int'(out[3]), 1);
        end
        gate[3] = 1'b1;
        cnt = 0;
        while (out[3] == 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        chk("gate_len", cnt, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
